// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, field positions and fixed values
// used by the interrupt/exception controller.
package cp0_pkg;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam int SR_IE    = 0;
    localparam int SR_EXL   = 1;
    localparam int IM_LO    = 10;
    localparam int IM_HI    = 15;
    localparam int IP_LO    = 10;
    localparam int IP_HI    = 15;
    localparam int EXC_LO   = 2;
    localparam int EXC_HI   = 6;
    localparam int CAUSE_BD = 31;

    localparam logic [31:0] PRID_VALUE = 32'h2206_0007;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

    typedef enum logic {
        NORMAL  = 1'b0,
        HANDLER = 1'b1
    } cp0_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/cp0_int_ctrl.sv
// CP0 interrupt/exception controller: SR, Cause, EPC and the flush request.
// Define CP0_PRID_EN to make register 15 return PRID_VALUE.
module cp0_int_ctrl
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic [4:0]  exc_code_in,
    input  logic [5:0]  hw_int,
    input  logic        exl_clr,
    output logic        req,
    output logic [31:0] epc_out
);

    cp0_state_e  state, state_nxt;
    logic [5:0]  sr_im;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;
    logic        rst_d;

    logic exl;
    logic int_req, exc_req;
    logic sr_wr, epc_wr;

    assign exl     = (state == HANDLER);
    assign int_req = ~exl & sr_ie & |(sr_im & hw_int);
    assign exc_req = ~exl & (exc_code_in != 5'd0);

    // rst_d masks the cycle right after reset so a stale exception code
    // cannot flush the pipeline before it has restarted.
    assign req     = ~reset & ~rst_d & (int_req | exc_req);

    assign sr_wr   = en & ~req & (addr == REG_SR);
    assign epc_wr  = en & ~req & (addr == REG_EPC);

    assign epc_out = epc_wr ? word_align(wdata) : epc;

    always_ff @(posedge clk) begin
        if (reset) state <= NORMAL;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            NORMAL: begin
                if (req)
                    state_nxt = HANDLER;
                else if (sr_wr && wdata[SR_EXL] && !exl_clr)
                    state_nxt = HANDLER;
            end
            HANDLER: begin
                if (exl_clr)
                    state_nxt = NORMAL;
                else if (sr_wr && !wdata[SR_EXL])
                    state_nxt = NORMAL;
            end
            default: state_nxt = NORMAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im     <= '0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc       <= '0;
            rst_d     <= 1'b1;
        end else begin
            rst_d    <= 1'b0;
            cause_ip <= hw_int;
            if (req) begin
                cause_bd  <= bd_in;
                cause_exc <= int_req ? 5'd0 : exc_code_in;
                epc       <= word_align(bd_in ? (vpc - 32'd4) : vpc);
            end else begin
                if (sr_wr) begin
                    sr_im <= wdata[IM_HI:IM_LO];
                    sr_ie <= wdata[SR_IE];
                end
                if (epc_wr)
                    epc <= word_align(wdata);
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            REG_SR: begin
                rdata[IM_HI:IM_LO] = sr_im;
                rdata[SR_EXL]      = exl;
                rdata[SR_IE]       = sr_ie;
            end
            REG_CAUSE: begin
                rdata[CAUSE_BD]      = cause_bd;
                rdata[IP_HI:IP_LO]   = cause_ip;
                rdata[EXC_HI:EXC_LO] = cause_exc;
            end
            REG_EPC:  rdata = epc;
`ifdef CP0_PRID_EN
            REG_PRID: rdata = PRID_VALUE;
`endif
            default:  rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Directed bench for cp0_int_ctrl: vector table plus reset corner sequences.
module tb_cp0_int_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        exl_clr;
    logic        req;
    logic [31:0] epc_out;

    int n_cmp = 0;
    int n_bad = 0;

    cp0_int_ctrl dut (
        .clk(clk), .reset(reset), .en(en), .addr(addr), .wdata(wdata),
        .rdata(rdata), .vpc(vpc), .bd_in(bd_in), .exc_code_in(exc_code_in),
        .hw_int(hw_int), .exl_clr(exl_clr), .req(req), .epc_out(epc_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] vpc;
        logic        bd;
        logic [4:0]  exc;
        logic [5:0]  hw;
        logic        clr;
        logic        e_req;
        logic [31:0] e_epc;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vt[24];

    function automatic vec_t mk(input logic e, input logic [4:0] a, input logic [31:0] wd,
                                input logic [31:0] pc, input logic b, input logic [4:0] x,
                                input logic [5:0] h, input logic c, input logic r,
                                input logic [31:0] ep, input logic [31:0] rd);
        vec_t v;
        v.en = e; v.addr = a; v.wdata = wd; v.vpc = pc; v.bd = b; v.exc = x;
        v.hw = h; v.clr = c; v.e_req = r; v.e_epc = ep; v.e_rd = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle();
        en = 0; addr = 0; wdata = 0; vpc = 0; bd_in = 0;
        exc_code_in = 0; hw_int = 0; exl_clr = 0;
    endtask

    logic [31:0] prid_exp;

    initial begin
`ifdef CP0_PRID_EN
        prid_exp = 32'h2206_0007;
`else
        prid_exp = 32'h0;
`endif
        //            en a   wdata         vpc           bd exc  hw       clr req epc_out       rdata
        vt[0]  = mk(1, 12, 32'h0000_0401, 32'h0,       0, 0,  6'b000000, 0, 0, 32'h0,       32'h0);
        vt[1]  = mk(0, 12, 32'h0,         32'h3010,    0, 0,  6'b000100, 0, 0, 32'h0,       32'h0000_0401);
        vt[2]  = mk(1, 12, 32'h0000_1001, 32'h0,       0, 0,  6'b000100, 0, 0, 32'h0,       32'h0000_0401);
        vt[3]  = mk(0, 13, 32'h0,         32'h3010,    0, 0,  6'b000100, 0, 1, 32'h0,       32'h0000_1000);
        vt[4]  = mk(0, 14, 32'h0,         32'h0,       0, 0,  6'b000100, 0, 0, 32'h3010,    32'h3010);
        vt[5]  = mk(0, 13, 32'h0,         32'h0,       0, 0,  6'b000100, 0, 0, 32'h3010,    32'h0000_1000);
        vt[6]  = mk(0, 12, 32'h0,         32'h0,       0, 0,  6'b000100, 0, 0, 32'h3010,    32'h0000_1003);
        vt[7]  = mk(1, 12, 32'h0000_1003, 32'h0,       0, 0,  6'b000100, 1, 0, 32'h3010,    32'h0000_1003);
        vt[8]  = mk(0, 12, 32'h0,         32'h3050,    0, 0,  6'b000100, 0, 1, 32'h3010,    32'h0000_1001);
        vt[9]  = mk(0, 14, 32'h0,         32'h0,       0, 0,  6'b000000, 1, 0, 32'h3050,    32'h3050);
        vt[10] = mk(0, 13, 32'h0,         32'h3024,    1, 4,  6'b000000, 0, 1, 32'h3050,    32'h0);
        vt[11] = mk(0, 13, 32'h0,         32'h0,       0, 4,  6'b000000, 0, 0, 32'h3020,    32'h8000_0010);
        vt[12] = mk(0, 14, 32'h0,         32'h0,       0, 0,  6'b000000, 1, 0, 32'h3020,    32'h3020);
        vt[13] = mk(0, 12, 32'h0,         32'h3100,    0, 10, 6'b000100, 0, 1, 32'h3020,    32'h0000_1001);
        vt[14] = mk(0, 13, 32'h0,         32'h0,       0, 0,  6'b000100, 0, 0, 32'h3100,    32'h0000_1000);
        vt[15] = mk(1, 14, 32'h0000_3047, 32'h0,       0, 0,  6'b000000, 0, 0, 32'h3044,    32'h3100);
        vt[16] = mk(0, 14, 32'h0,         32'h0,       0, 0,  6'b000000, 0, 0, 32'h3044,    32'h3044);
        vt[17] = mk(0, 12, 32'h0,         32'h0,       0, 0,  6'b000000, 1, 0, 32'h3044,    32'h0000_1003);
        vt[18] = mk(1, 14, 32'h0000_5555, 32'h3200,    0, 8,  6'b000000, 0, 1, 32'h3044,    32'h3044);
        vt[19] = mk(0, 14, 32'h0,         32'h0,       0, 0,  6'b000000, 0, 0, 32'h3200,    32'h3200);
        vt[20] = mk(0, 13, 32'h0,         32'h0,       0, 0,  6'b000000, 0, 0, 32'h3200,    32'h0000_0020);
        vt[21] = mk(1, 15, 32'hFFFF_FFFF, 32'h0,       0, 0,  6'b000000, 0, 0, 32'h3200,    prid_exp);
        vt[22] = mk(0, 15, 32'h0,         32'h0,       0, 0,  6'b000000, 0, 0, 32'h3200,    prid_exp);
        vt[23] = mk(0, 3,  32'h0,         32'h0,       0, 0,  6'b000000, 0, 0, 32'h3200,    32'h0);

        // Reset with a pending exception code: req must stay low through
        // reset and the first cycle after it.
        idle();
        reset = 1;
        exc_code_in = 5'd4;
        #3 chk("req_in_reset", {31'b0, req}, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        reset = 0;
        #3 chk("req_first_after_reset", {31'b0, req}, 32'h0);
        chk("sr_after_reset", rdata, 32'h0);
        @(posedge clk); #1;
        exc_code_in = 0;
        addr = 13;
        #1 chk("cause_after_reset", rdata, 32'h0);
        addr = 14;
        #1 chk("epc_after_reset", rdata, 32'h0);
        chk("epc_out_after_reset", epc_out, 32'h0);
        @(posedge clk); #1;

        for (int i = 0; i < 24; i++) begin
            en = vt[i].en; addr = vt[i].addr; wdata = vt[i].wdata; vpc = vt[i].vpc;
            bd_in = vt[i].bd; exc_code_in = vt[i].exc; hw_int = vt[i].hw; exl_clr = vt[i].clr;
            #3;
            chk($sformatf("v%0d_req", i), {31'b0, req}, {31'b0, vt[i].e_req});
            chk($sformatf("v%0d_epc_out", i), epc_out, vt[i].e_epc);
            chk($sformatf("v%0d_rdata", i), rdata, vt[i].e_rd);
            @(posedge clk); #1;
        end

        // Reset mid-handler (EXL=1 here) overrides a same-cycle mtc0 and exception.
        idle();
        reset = 1; en = 1; addr = 12; wdata = 32'h0000_1001; exc_code_in = 5'd4;
        #3 chk("req_reset_mid_handler", {31'b0, req}, 32'h0);
        @(posedge clk); #1;
        reset = 0; en = 0;
        #3 chk("req_post_reset2", {31'b0, req}, 32'h0);
        chk("sr_post_reset2", rdata, 32'h0);
        @(posedge clk); #1;
        addr = 13;
        #1 chk("cause_post_reset2", rdata, 32'h0);
        addr = 14;
        #1 chk("epc_post_reset2", rdata, 32'h0);
        chk("req_second_after_reset", {31'b0, req}, 32'h1);
        @(posedge clk); #1;
        idle();
        addr = 14;
        #1 chk("epc_after_exc_post_reset", rdata, 32'h0);
        addr = 13;
        #1 chk("cause_after_exc_post_reset", rdata, 32'h0000_0010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
